alits_sar_seq: RTL and testbench

//   Digital sequencer for the on-die analog SAR front-end on ua[5:0].

---
 rtl/alits_pkg.sv | 23 ++
 rtl/alits_rr_pick.sv | 38 +++
 rtl/alits_sar_seq.sv | 136 +++++++++++++
 tb/tb_alits_sar_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alits_pkg.sv
// rtl/alits_pkg.sv - shared types and constants for the SAR front-end sequencer
package alits_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_TRACK,
        ST_CONVERT,
        ST_DONE
    } state_t;

    localparam int DEF_NBITS   = 8;
    localparam int DEF_NCH     = 4;
    localparam int DEF_TRACK   = 4;
    localparam int DEF_SETTLE  = 2;
    localparam int SYNC_STAGES = 2;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alits_rr_pick.sv
// rtl/alits_rr_pick.sv - combinational search for the next enabled channel after a pointer
module alits_rr_pick #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] mask,
    input  logic [CHW-1:0] ptr,
    output logic [CHW-1:0] idx,
    output logic           found
);
    localparam int SW = CHW + 2;

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [SW-1:0]    shamt;
    logic [CHW-1:0]   off;
    logic [SW-1:0]    sum;

    // Rotate so bit 0 of rot is the channel right after ptr; the lowest set bit wins.
    assign dbl   = {mask, mask};
    assign shamt = SW'(ptr) + SW'(1);
    assign rot   = NCH'(dbl >> shamt);

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = CHW'(i);
                found = 1'b1;
            end
        end
    end

    assign sum = SW'(ptr) + SW'(off) + SW'(1);
    assign idx = (sum >= SW'(NCH)) ? CHW'(sum - SW'(NCH)) : CHW'(sum);

endmodule

// File: rtl/alits_sar_seq.sv
// rtl/alits_sar_seq.sv - round-robin track/hold and MSB-first SAR sequencer for the analog front-end
module alits_sar_seq
    import alits_pkg::*;
#(
    parameter int  NBITS  = DEF_NBITS,
    parameter int  NCH    = DEF_NCH,
    parameter int  TRACK  = DEF_TRACK,
    parameter int  SETTLE = DEF_SETTLE,
    localparam int CHW    = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             cmp,
    output logic [CHW-1:0]   ch_sel,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             res_valid,
    output logic [NBITS-1:0] res_data,
    output logic [CHW-1:0]   res_ch
);
    // The synchronizer delay is part of each bit's dwell, not added on top.
    localparam int DWELL   = SETTLE + SYNC_STAGES;
    localparam int CNT_MAX = (TRACK > DWELL) ? TRACK : DWELL;
    localparam int CNTW    = ch_width(CNT_MAX);
    localparam int BW      = ch_width(NBITS);

    state_t           state;
    state_t           state_nxt;
    logic             cmp_s1;
    logic             cmp_s2;
    logic [CHW-1:0]   ptr;
    logic [CHW-1:0]   pick_idx;
    logic             pick_found;
    logic [CNTW-1:0]  cnt;
    logic [BW-1:0]    kbit;
    logic [NBITS-1:0] code;
    logic [NBITS-1:0] code_upd;
    logic [NBITS-1:0] trial;
    logic             track_last;
    logic             dwell_last;
    logic             bit_last;

    alits_rr_pick #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_pick (
        .mask  (ch_mask),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign track_last = (cnt == CNTW'(TRACK - 1));
    assign dwell_last = (cnt == CNTW'(DWELL - 1));
    assign bit_last   = (kbit == '0);

    // Bits below kbit are still zero in code, so setting bit kbit forms the trial.
    always_comb begin
        trial       = code;
        trial[kbit] = 1'b1;
        code_upd       = code;
        code_upd[kbit] = cmp_s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmp_s1   <= 1'b0;
            cmp_s2   <= 1'b0;
            ptr      <= CHW'(NCH - 1);
            ch_sel   <= '0;
            cnt      <= '0;
            kbit     <= '0;
            code     <= '0;
            res_data <= '0;
            res_ch   <= '0;
        end else begin
            state  <= state_nxt;
            cmp_s1 <= cmp;
            cmp_s2 <= cmp_s1;
            case (state)
                ST_SELECT: begin
                    if (pick_found) begin
                        ch_sel <= pick_idx;
                        ptr    <= pick_idx;
                    end
                    cnt  <= '0;
                    kbit <= BW'(NBITS - 1);
                    code <= '0;
                end
                ST_TRACK: begin
                    cnt <= track_last ? '0 : cnt + CNTW'(1);
                end
                ST_CONVERT: begin
                    if (dwell_last) begin
                        cnt  <= '0;
                        code <= code_upd;
                        if (bit_last) begin
                            res_data <= code_upd;
                            res_ch   <= ch_sel;
                        end else begin
                            kbit <= kbit - BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start && |ch_mask) state_nxt = ST_SELECT;
            ST_SELECT:  state_nxt = pick_found ? ST_TRACK : ST_IDLE;
            ST_TRACK:   if (track_last) state_nxt = ST_CONVERT;
            ST_CONVERT: if (dwell_last && bit_last) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = (cont && |ch_mask) ? ST_SELECT : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        sample    = (state == ST_TRACK);
        dac_code  = (state == ST_CONVERT) ? trial : '0;
        res_valid = (state == ST_DONE);
    end

endmodule

// File: tb/tb_alits_sar_seq.sv
// tb/tb_alits_sar_seq.sv - self-checking bench for alits_sar_seq
module tb_alits_sar_seq;
    localparam int NBITS  = 8;
    localparam int NCH    = 4;
    localparam int TRACK  = 4;
    localparam int SETTLE = 2;
    localparam int CHW    = 2;
    localparam int LAT    = 2 + TRACK + NBITS * (SETTLE + 2);
    localparam int CV0    = 2 + TRACK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cont;
    logic [NCH-1:0]   ch_mask;
    logic             cmp;
    logic [CHW-1:0]   ch_sel;
    logic             sample;
    logic [NBITS-1:0] dac_code;
    logic             busy;
    logic             res_valid;
    logic [NBITS-1:0] res_data;
    logic [CHW-1:0]   res_ch;

    alits_sar_seq #(
        .NBITS  (NBITS),
        .NCH    (NCH),
        .TRACK  (TRACK),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .ch_mask   (ch_mask),
        .cmp       (cmp),
        .ch_sel    (ch_sel),
        .sample    (sample),
        .dac_code  (dac_code),
        .busy      (busy),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ch    (res_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Analog input sits half an LSB above its code, so an ideal SAR returns the code.
    logic [NBITS-1:0] vin [NCH];
    int cmp_mode;
    always_comb begin
        case (cmp_mode)
            1:       cmp = 1'b1;
            2:       cmp = 1'b0;
            default: cmp = (vin[ch_sel] >= dac_code);
        endcase
    end

    typedef struct {
        int ch;
        int data;
        int at;
    } res_t;
    res_t resq[$];

    always @(negedge clk) begin
        if (res_valid) resq.push_back('{int'(res_ch), int'(res_data), cyc});
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        cont  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resq.delete();
    endtask

    task automatic pulse_start(output int at);
        @(negedge clk);
        start = 1'b1;
        at    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(output res_t r, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        r  = '{-1, -1, -1};
        while (resq.size() == 0 && n < 2 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (resq.size() > 0) begin
            r  = resq.pop_front();
            ok = 1'b1;
        end else begin
            check("result_timeout", 32'd0, 32'd1);
        end
    endtask

    function automatic int model_pick(input int mask, inout int ptr);
        for (int step = 1; step <= NCH; step++) begin
            int c;
            c = (ptr + step) % NCH;
            if ((mask >> c) & 1) begin
                ptr = c;
                return c;
            end
        end
        return -1;
    endfunction

    typedef struct {
        int             mode;
        logic [NCH-1:0] mask;
        logic [7:0]     v;
        int             exp_ch;
        int             exp_data;
    } vec_t;
    vec_t vecs[6];

    initial begin
        automatic int   at = 0;
        automatic int   prev_at = 0;
        automatic res_t r;
        automatic bit   ok;
        automatic int   mptr;
        automatic int   exp_ch;
        automatic int   exp_chs[5] = '{1, 3, 1, 3, 1};
        automatic int   mfor[8];
        automatic int   nconv;
        automatic bit   saw_busy;

        rst      = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        ch_mask  = '0;
        cmp_mode = 0;
        for (int i = 0; i < NCH; i++) vin[i] = '0;

        vecs[0] = '{0, 4'b0001, 8'h5A, 0, 8'h5A};
        vecs[1] = '{1, 4'b0100, 8'h00, 2, 8'hFF};
        vecs[2] = '{2, 4'b1000, 8'h33, 3, 8'h00};
        vecs[3] = '{0, 4'b1010, 8'h00, 1, 8'h00};
        vecs[4] = '{0, 4'b1100, 8'hFF, 2, 8'hFF};
        vecs[5] = '{0, 4'b0110, 8'h81, 1, 8'h81};

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_sample", sample, 0);
        check("rst_dac_code", dac_code, 0);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_ch", res_ch, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            cmp_mode = vecs[v].mode;
            ch_mask  = vecs[v].mask;
            for (int i = 0; i < NCH; i++) vin[i] = vecs[v].v;
            pulse_start(at);
            wait_result(r, ok);
            if (ok) begin
                check("vec_latency", r.at - at, LAT);
                check("vec_res_ch", r.ch, vecs[v].exp_ch);
                check("vec_res_data", r.data, vecs[v].exp_data);
            end
            repeat (2) @(negedge clk);
            check("vec_idle_busy", busy, 0);
            check("vec_hold_data", res_data, vecs[v].exp_data);
        end

        // Trial code sequence with the comparator tied high and tied low.
        for (int m = 1; m <= 2; m++) begin
            do_reset();
            cmp_mode = m;
            ch_mask  = 4'b0001;
            pulse_start(at);
            check("trial_busy_select", busy, 1);
            for (int n = 2; n < LAT; n++) begin
                automatic int k;
                automatic int exp_dac;
                @(negedge clk);
                if (n < CV0) begin
                    check("track_sample", sample, 1);
                    check("track_dac", dac_code, 0);
                end else begin
                    k = NBITS - 1 - (n - CV0) / (SETTLE + 2);
                    exp_dac = (m == 1) ? ((32'hFF << k) & 32'hFF) : (1 << k);
                    check("conv_sample", sample, 0);
                    check("conv_dac_trial", dac_code, exp_dac);
                end
            end
            wait_result(r, ok);
            if (ok) check("trial_result", r.data, (m == 1) ? 8'hFF : 8'h00);
        end

        // Continuous scan over channels 1 and 3, then cont dropped.
        do_reset();
        cmp_mode = 0;
        vin[1]   = 8'h11;
        vin[3]   = 8'hC3;
        ch_mask  = 4'b1010;
        cont     = 1'b1;
        pulse_start(at);
        prev_at = at;
        for (int j = 0; j < 5; j++) begin
            wait_result(r, ok);
            if (ok) begin
                check("cont_res_ch", r.ch, exp_chs[j]);
                check("cont_res_data", r.data, vin[exp_chs[j]]);
                check("cont_spacing", r.at - prev_at, LAT);
                prev_at = r.at;
            end
            if (j == 3) begin
                repeat (2) @(negedge clk);
                cont = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("cont_stop_busy", busy, 0);
        check("cont_stop_extra", resq.size(), 0);

        // start with an empty mask is dropped.
        do_reset();
        ch_mask = '0;
        pulse_start(at);
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("nomask_busy", saw_busy, 0);
        check("nomask_results", resq.size(), 0);

        // Extra starts while busy do not queue.
        ch_mask = 4'b0001;
        vin[0]  = 8'h42;
        pulse_start(at);
        repeat (10) @(negedge clk);
        pulse_start(at);
        repeat (10) @(negedge clk);
        pulse_start(at);
        repeat (80) @(negedge clk);
        check("busy_start_count", resq.size(), 1);
        check("busy_start_idle", busy, 0);

        // Reset during bit 4 of a conversion on channel 1.
        do_reset();
        cmp_mode = 0;
        vin[0]   = 8'h10;
        vin[1]   = 8'h20;
        vin[2]   = 8'h30;
        vin[3]   = 8'h40;
        ch_mask  = 4'b1111;
        pulse_start(at);
        wait_result(r, ok);
        if (ok) check("pre_rst_ch", r.ch, 0);
        repeat (3) @(negedge clk);
        pulse_start(at);
        repeat (CV0 + 4 * (NBITS - 1 - 4) + 1 - 1) @(negedge clk);
        check("bit4_trial", dac_code, 8'h30);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sample", sample, 0);
        check("mid_rst_dac", dac_code, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_ch_sel", ch_sel, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_res_ch", res_ch, 0);
        rst = 1'b0;
        check("mid_rst_no_result", resq.size(), 0);
        pulse_start(at);
        wait_result(r, ok);
        if (ok) begin
            check("post_rst_ch", r.ch, 0);
            check("post_rst_data", r.data, 8'h10);
            check("post_rst_latency", r.at - at, LAT);
        end

        // cont cleared during TRACK still completes the conversion.
        do_reset();
        ch_mask = 4'b0100;
        vin[2]  = 8'hA7;
        cont    = 1'b1;
        pulse_start(at);
        @(negedge clk);
        cont = 1'b0;
        wait_result(r, ok);
        if (ok) check("cont_drop_data", r.data, 8'hA7);
        repeat (LAT + 5) @(negedge clk);
        check("cont_drop_count", resq.size(), 0);
        check("cont_drop_busy", busy, 0);

        // Randomized scans with mask changes against the round-robin model.
        do_reset();
        cmp_mode = 0;
        mptr     = NCH - 1;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NCH; i++) vin[i] = NBITS'($urandom_range(0, 255));
            nconv   = int'($urandom_range(2, 4));
            mfor[0] = int'($urandom_range(1, 15));
            mfor[1] = mfor[0];
            ch_mask = NCH'(mfor[0]);
            cont    = 1'b1;
            pulse_start(at);
            prev_at = at;
            for (int j = 0; j < nconv; j++) begin
                wait_result(r, ok);
                exp_ch = model_pick(mfor[j], mptr);
                if (ok) begin
                    check("rand_res_ch", r.ch, exp_ch);
                    check("rand_res_data", r.data, vin[exp_ch]);
                    check("rand_spacing", r.at - prev_at, LAT);
                    prev_at = r.at;
                end
                if (j < nconv - 1) begin
                    repeat (2) @(negedge clk);
                    mfor[j + 2] = int'($urandom_range(1, 15));
                    ch_mask     = NCH'(mfor[j + 2]);
                    if (j == nconv - 2) cont = 1'b0;
                end
            end
            repeat (3) @(negedge clk);
            check("rand_idle_busy", busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
